mips_io_ports: RTL

- Parametrised, memory-mapped I/O port controller for the Mips core; generalises the single fixed 16-bit InPort/OutPort pair.
- Supports NUM_PORTS independent channels of WIDTH bits each.
- Each channel provides:
  - a registered output port;
  - a synchronised input port with sticky change detection;
  - a per-channel interrupt enable.
- Sits between the core's load/store data bus and the external pins.

---
 rtl/mips_io_pkg.sv | 13 +
 rtl/mips_io_channel.sv | 73 +++++++
 rtl/mips_io_ports.sv | 90 +++++++++
 3 files changed

// File: rtl/mips_io_pkg.sv
// Shared constants for the Mips memory-mapped I/O port controller:
// per-channel register offsets and control/status bit positions.
package mips_io_pkg;

  localparam logic [1:0] OFF_OUT    = 2'd0;
  localparam logic [1:0] OFF_IN     = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int STATUS_CHG = 0;
  localparam int CTRL_IE    = 0;

endpackage

// File: rtl/mips_io_channel.sv
// One I/O channel: output register, two-flop input synchroniser with sticky
// change detection, interrupt enable and the channel's read mux.
module mips_io_channel
  import mips_io_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sel,
  input  logic [1:0]       off,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] in_pin,
  output logic [WIDTH-1:0] out_val,
  output logic [WIDTH-1:0] rd_val,
  output logic             irq_req
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] prev;
  logic             chg;
  logic             ie;
  logic             wr_sel;
  logic             chg_set;
  logic             chg_clr;

  assign wr_sel  = wr_en & sel;
  assign chg_set = (s2 != prev);
  assign chg_clr = wr_sel & (off == OFF_STATUS) & wdata[STATUS_CHG];
  assign irq_req = chg & ie;

  // Register state; a fresh change beats a same-cycle write-1-to-clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      prev    <= '0;
      out_val <= '0;
      chg     <= 1'b0;
      ie      <= 1'b0;
    end else begin
      s1   <= in_pin;
      s2   <= s1;
      prev <= s2;
      if (wr_sel && (off == OFF_OUT)) begin
        out_val <= wdata;
      end
      if (wr_sel && (off == OFF_CTRL)) begin
        ie <= wdata[CTRL_IE];
      end
      if (chg_set) begin
        chg <= 1'b1;
      end else if (chg_clr) begin
        chg <= 1'b0;
      end
    end
  end

  // Read mux over current register contents (pre-write values).
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_OUT:    rd_val = out_val;
      OFF_IN:     rd_val = s2;
      OFF_STATUS: rd_val[STATUS_CHG] = chg;
      OFF_CTRL:   rd_val[CTRL_IE] = ie;
      default:    rd_val = '0;
    endcase
  end

endmodule

// File: rtl/mips_io_ports.sv
// Memory-mapped I/O port controller: decodes the word address into channel
// and register offset, registers read data and ORs channel interrupts.
module mips_io_ports
  import mips_io_pkg::*;
#(
  parameter int  WIDTH     = 16,
  parameter int  NUM_PORTS = 2,
  localparam int ADDR_W    = $clog2(NUM_PORTS) + 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rdata,
  output logic                       rvalid,
  input  logic [NUM_PORTS*WIDTH-1:0] in_port,
  output logic [NUM_PORTS*WIDTH-1:0] out_port,
  output logic                       irq
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IDX_W-1:0]     ch_idx;
  logic [1:0]           off;
  logic [NUM_PORTS-1:0] sel;
  logic [NUM_PORTS-1:0] irq_vec;
  logic [WIDTH-1:0]     rd_vals [NUM_PORTS];
  logic [WIDTH-1:0]     rd_mux;

  assign off = addr[1:0];

  if (NUM_PORTS > 1) begin : g_idx
    assign ch_idx = addr[ADDR_W-1:2];
  end else begin : g_idx_single
    assign ch_idx = 1'b0;
  end

  // Channel select; an index beyond NUM_PORTS matches nothing.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      sel[k] = (ch_idx == IDX_W'(k));
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
    mips_io_channel #(.WIDTH(WIDTH)) u_ch (
      .clock   (clock),
      .reset   (reset),
      .sel     (sel[g]),
      .off     (off),
      .wr_en   (wr_en),
      .wdata   (wdata),
      .in_pin  (in_port[g*WIDTH +: WIDTH]),
      .out_val (out_port[g*WIDTH +: WIDTH]),
      .rd_val  (rd_vals[g]),
      .irq_req (irq_vec[g])
    );
  end

  // Read data from the selected channel; zero when out of range.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (sel[k]) begin
        rd_mux = rd_mux | rd_vals[k];
      end else begin
        rd_mux = rd_mux;
      end
    end
  end

  // Registered read response; rdata holds between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

  assign irq = |irq_vec;

endmodule
